// File: rtl/param_acc_datapath.sv
// Accumulator-machine datapath: AC/PC/IR/carry/MQ, combinational ALU, muxed
// address/data paths and a sequential shift-add multiplier (AC * IR operand).
module param_acc_datapath #(
  parameter int DW  = 16,
  parameter int OPW = 3,
  parameter int AW  = DW - OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  mem_rdata,
  output logic [DW-1:0]  mem_wdata,
  output logic [AW-1:0]  adr,
  input  logic           pc_on_adr,
  input  logic           ir_on_adr,
  input  logic           dbus_sel,
  input  logic           ld_ir,
  input  logic           ld_pc,
  input  logic           inc_pc,
  input  logic           clr_pc,
  input  logic           ld_ac,
  input  logic           ac_ldimm,
  input  logic           ac_inc,
  input  logic           ac_shr,
  input  logic           ac_shl,
  input  logic           ac_zero,
  input  logic [2:0]     alu_op,
  input  logic           set_carry,
  input  logic           clr_carry,
  input  logic           mul_start,
  output logic [OPW-1:0] op_code,
  output logic           zero_flag,
  output logic           carry_flag,
  output logic [DW-1:0]  mq,
  output logic           mul_busy,
  output logic           mul_done,
  output logic           bus_err
);
  localparam int PW = DW + AW;
  localparam int CW = (AW > 1) ? $clog2(AW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mstate_t;

  logic [DW-1:0] ac, ir, alu_y, dbus, opnd;
  logic [AW-1:0] pc;
  logic          carry_q, alu_arith;
  logic [DW:0]   sum;
  mstate_t       state_q, state_d;
  logic [PW-1:0] mcand, prod, prod_nxt;
  logic [AW-1:0] mplier;
  logic [CW-1:0] cnt;
  logic          mul_last, mul_idle;

  assign opnd       = DW'(ir[AW-1:0]);
  assign op_code    = ir[DW-1:DW-OPW];
  assign mem_wdata  = ac;
  assign zero_flag  = (ac == '0);
  assign carry_flag = carry_q;
  assign dbus       = dbus_sel ? alu_y : mem_rdata;
  assign adr        = pc_on_adr ? pc : (ir_on_adr ? ir[AW-1:0] : '0);

  always_comb begin
    sum       = '0;
    alu_y     = '0;
    alu_arith = 1'b0;
    case (alu_op)
      3'd0: alu_y = opnd;
      3'd1: begin sum = {1'b0, ac} + {1'b0, opnd}; alu_arith = 1'b1; end
      3'd2: begin sum = {1'b0, ac} + {1'b0, opnd} + (DW+1)'(carry_q); alu_arith = 1'b1; end
      3'd3: begin sum = {1'b0, ac} + {1'b0, ~opnd} + (DW+1)'(1); alu_arith = 1'b1; end
      3'd4: alu_y = ac & opnd;
      3'd5: alu_y = ac | opnd;
      3'd6: alu_y = ac ^ opnd;
      default: alu_y = ~ac;
    endcase
    if (alu_arith) alu_y = sum[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_q <= 1'b0;
    else if (clr_carry) carry_q <= 1'b0;
    else if (set_carry) carry_q <= 1'b1;
    else if (ld_ac && dbus_sel && alu_arith) carry_q <= sum[DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (clr_pc) pc <= '0;
    else if (ld_pc) pc <= ir[AW-1:0];
    else if (inc_pc) pc <= pc + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ir <= '0;
    else if (ld_ir) ir <= dbus;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_err <= 1'b0;
    else if (pc_on_adr && ir_on_adr) bus_err <= 1'b1;
  end

  // Multiplier control
  assign mul_idle = (state_q == IDLE);
  assign mul_last = (cnt == CW'(AW-1));
  assign mul_busy = (state_q == RUN);
  assign mul_done = (state_q == DONE);
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = RUN;
      RUN:     if (mul_last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (mul_idle && mul_start) begin
      mcand  <= PW'(ac);
      mplier <= ir[AW-1:0];
      prod   <= '0;
      cnt    <= '0;
    end else if (mul_busy) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // Product writeback beats any strobe; strobes only act while the multiplier is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac <= '0;
      mq <= '0;
    end else if (mul_busy && mul_last) begin
      ac <= prod_nxt[DW-1:0];
      mq <= DW'(prod_nxt[PW-1:DW]);
    end else if (mul_idle) begin
      if      (ac_zero)  ac <= '0;
      else if (ld_ac)    ac <= dbus;
      else if (ac_ldimm) ac <= opnd;
      else if (ac_inc)   ac <= ac + DW'(1);
      else if (ac_shr)   ac <= ac >> 1;
      else if (ac_shl)   ac <= ac << 1;
    end
  end
endmodule

// File: tb/tb_param_acc_datapath.sv
// Directed bench for param_acc_datapath with hand-computed expectations.
module tb_param_acc_datapath;
  localparam int DW = 16, OPW = 3, AW = 13;

  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] mem_rdata, mem_wdata, mq;
  logic [AW-1:0] adr;
  logic pc_on_adr, ir_on_adr, dbus_sel, ld_ir, ld_pc, inc_pc, clr_pc;
  logic ld_ac, ac_ldimm, ac_inc, ac_shr, ac_shl, ac_zero;
  logic [2:0] alu_op;
  logic set_carry, clr_carry, mul_start;
  logic [OPW-1:0] op_code;
  logic zero_flag, carry_flag, mul_busy, mul_done, bus_err;

  int errors = 0, checks = 0;

  param_acc_datapath #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .adr(adr),
    .pc_on_adr(pc_on_adr), .ir_on_adr(ir_on_adr), .dbus_sel(dbus_sel), .ld_ir(ld_ir),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .clr_pc(clr_pc), .ld_ac(ld_ac), .ac_ldimm(ac_ldimm),
    .ac_inc(ac_inc), .ac_shr(ac_shr), .ac_shl(ac_shl), .ac_zero(ac_zero), .alu_op(alu_op),
    .set_carry(set_carry), .clr_carry(clr_carry), .mul_start(mul_start), .op_code(op_code),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .mq(mq), .mul_busy(mul_busy),
    .mul_done(mul_done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    {pc_on_adr, ir_on_adr, dbus_sel, ld_ir, ld_pc, inc_pc, clr_pc} = '0;
    {ld_ac, ac_ldimm, ac_inc, ac_shr, ac_shl, ac_zero} = '0;
    {set_carry, clr_carry, mul_start} = '0;
    alu_op = 3'd0;
    mem_rdata = '0;
  endtask

  task automatic load_ac(input logic [DW-1:0] v);
    mem_rdata = v; dbus_sel = 1'b0; ld_ac = 1'b1;
    tick();
    ld_ac = 1'b0;
  endtask

  task automatic load_ir(input logic [DW-1:0] v);
    mem_rdata = v; dbus_sel = 1'b0; ld_ir = 1'b1;
    tick();
    ld_ir = 1'b0;
  endtask

  initial begin
    int n;
    idle_in();
    #12 rst = 1'b0;
    tick();
    chk("reset_ac", mem_wdata, 16'h0000);
    chk("reset_zero_flag", zero_flag, 1'b1);

    // 1: async reset mid-multiply
    load_ac(16'h1234);
    pc_on_adr = 1'b1; ir_on_adr = 1'b1;
    tick();
    pc_on_adr = 1'b0; ir_on_adr = 1'b0;
    chk("pre_rst_bus_err", bus_err, 1'b1);
    load_ir(16'h0010);
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    tick(); tick();
    chk("pre_rst_busy", mul_busy, 1'b1);
    chk("pre_rst_ac", mem_wdata, 16'h1234);
    #2 rst = 1'b1;
    #1;
    chk("rst_ac", mem_wdata, 16'h0000);
    chk("rst_ir_opcode", op_code, 3'd0);
    chk("rst_mq", mq, 16'h0000);
    chk("rst_carry", carry_flag, 1'b0);
    chk("rst_busy", mul_busy, 1'b0);
    chk("rst_done", mul_done, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    pc_on_adr = 1'b1; #1;
    chk("rst_pc", adr, 13'h0000);
    pc_on_adr = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", mul_busy, 1'b0);

    // 2: ADD carry out, then ADDC
    load_ac(16'hFFFF);
    load_ir(16'h0001);
    dbus_sel = 1'b1; alu_op = 3'd1; ld_ac = 1'b1;
    tick();
    chk("add_ac", mem_wdata, 16'h0000);
    chk("add_carry", carry_flag, 1'b1);
    chk("add_zero", zero_flag, 1'b1);
    alu_op = 3'd2;
    tick();
    ld_ac = 1'b0; dbus_sel = 1'b0;
    chk("addc_ac", mem_wdata, 16'h0002);
    chk("addc_carry", carry_flag, 1'b0);

    // 3: multiply 0x1234 * 0x0010
    load_ac(16'h1234);
    load_ir(16'h0010);
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    mem_rdata = 16'hDEAD; dbus_sel = 1'b0; ld_ac = 1'b1;
    n = 0;
    while (mul_busy && n < 50) begin
      n++;
      tick();
    end
    chk("mul_busy_cycles", n, 13);
    chk("mul_done_pulse", mul_done, 1'b1);
    chk("mul_done_busy_low", mul_busy, 1'b0);
    chk("mul_ac", mem_wdata, 16'h2340);
    chk("mul_mq", mq, 16'h0001);
    tick();
    ld_ac = 1'b0;
    chk("mul_done_one_cycle", mul_done, 1'b0);
    chk("mul_ac_held", mem_wdata, 16'h2340);

    // 4: PC wrap, ld_pc, clr_pc priority
    load_ir(16'h1FFF);
    ld_pc = 1'b1; tick(); ld_pc = 1'b0;
    pc_on_adr = 1'b1; #1;
    chk("pc_max", adr, 13'h1FFF);
    inc_pc = 1'b1; tick(); inc_pc = 1'b0;
    chk("pc_wrap", adr, 13'h0000);
    load_ir(16'h6ABC);
    ld_pc = 1'b1; tick(); ld_pc = 1'b0;
    chk("pc_ld", adr, 13'h0ABC);
    chk("op_code", op_code, 3'd3);
    clr_pc = 1'b1; inc_pc = 1'b1; tick(); clr_pc = 1'b0; inc_pc = 1'b0;
    chk("pc_clr_prio", adr, 13'h0000);

    // 5: address select and sticky bus_err
    inc_pc = 1'b1; tick(); tick(); inc_pc = 1'b0;
    chk("bus_err_clear", bus_err, 1'b0);
    ir_on_adr = 1'b1; #1;
    chk("adr_both_pc", adr, 13'h0002);
    tick();
    chk("bus_err_set", bus_err, 1'b1);
    pc_on_adr = 1'b0; #1;
    chk("adr_ir", adr, 13'h0ABC);
    ir_on_adr = 1'b0; #1;
    chk("adr_none", adr, 13'h0000);
    tick();
    chk("bus_err_sticky", bus_err, 1'b1);

    // 6: AC priority, SUB borrow, inc wrap
    load_ac(16'h0003);
    mem_rdata = 16'h00FF; ac_zero = 1'b1; ld_ac = 1'b1;
    tick();
    ac_zero = 1'b0; ld_ac = 1'b0;
    chk("ac_zero_prio", mem_wdata, 16'h0000);
    load_ac(16'h0003);
    load_ir(16'h0005);
    set_carry = 1'b1; tick(); set_carry = 1'b0;
    dbus_sel = 1'b1; alu_op = 3'd3; ld_ac = 1'b1;
    tick();
    ld_ac = 1'b0; dbus_sel = 1'b0;
    chk("sub_ac", mem_wdata, 16'hFFFE);
    chk("sub_borrow", carry_flag, 1'b0);
    ac_inc = 1'b1; tick();
    chk("inc_ac", mem_wdata, 16'hFFFF);
    tick(); ac_inc = 1'b0;
    chk("inc_wrap", mem_wdata, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_acc_datapath.md
Name: param_acc_datapath

Overview:
Parametrised accumulator-machine datapath: AC, PC, IR, carry flag, MQ (multiply-high) register and ALU, with muxed internal data/address paths replacing tri-state buses. Adds a sequential shift-add multiplier with busy/done handshake and a sticky address-select conflict flag. Sits between the control FSM, which drives all strobes, and the memory interface.

Parameters:
DW, 16, data width of AC, IR, MQ, memory data.
OPW, 3, opcode width taken from the IR MSBs.
AW, DW-OPW, address/operand width (IR low bits, PC width).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
mem_rdata  in  DW  memory read data
mem_wdata  out  DW  write data, always equals AC
adr  out  AW  memory address
pc_on_adr  in  1  drive adr from PC
ir_on_adr  in  1  drive adr from IR operand
dbus_sel  in  1  internal dbus source: 0 = mem_rdata, 1 = ALU
ld_ir  in  1  IR <= dbus
ld_pc  in  1  PC <= IR operand
inc_pc  in  1  PC <= PC+1
clr_pc  in  1  PC <= 0
ld_ac  in  1  AC <= dbus
ac_ldimm  in  1  AC <= zero-extended IR operand
ac_inc  in  1  AC <= AC+1
ac_shr  in  1  AC <= AC>>1 (logical)
ac_shl  in  1  AC <= AC<<1
ac_zero  in  1  AC <= 0
alu_op  in  3  0 PASS_B, 1 ADD, 2 ADDC, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT_A
set_carry  in  1  carry <= 1
clr_carry  in  1  carry <= 0
mul_start  in  1  start AC * operand
op_code  out  OPW  IR[DW-1:DW-OPW]
zero_flag  out  1  AC == 0
carry_flag  out  1  carry register
mq  out  DW  upper product bits, zero-extended
mul_busy  out  1  multiplier running
mul_done  out  1  one-cycle completion pulse
bus_err  out  1  sticky address-select conflict

Behaviour:
- Reset (async, any time, including mid-multiply): AC, PC, IR, MQ, carry, mul_busy, mul_done and bus_err are all 0; the multiplier returns to IDLE and any in-flight product is discarded.
- ALU is combinational. A = AC; B = IR[AW-1:0] zero-extended to DW. Results are truncated to DW bits.
- ADD/ADDC/SUB carry-out is bit DW of the (DW+1)-bit sum. ADDC adds carry_flag. SUB = A + ~B + 1, so carry=1 means no borrow.
- Carry update priority: clr_carry > set_carry > arithmetic update. Arithmetic update happens only when ld_ac=1, dbus_sel=1 and alu_op is ADD/ADDC/SUB. All other ops leave carry unchanged.
- AC write priority (highest wins, one per cycle): ac_zero > ld_ac > ac_ldimm > ac_inc > ac_shr > ac_shl. ac_inc wraps mod 2^DW.
- PC priority: clr_pc > ld_pc > inc_pc. PC wraps mod 2^AW.
- IR loads from dbus when ld_ir=1, independent of the AC strobes.
- adr selection:
  - pc_on_adr alone: PC.
  - ir_on_adr alone: IR operand.
  - Neither: 0.
  - Both: PC, and bus_err sets on that clock edge and stays set until rst.
- Multiplier FSM, states IDLE, RUN, DONE:
  - IDLE: mul_start=1 latches multiplicand=AC and multiplier=operand, clears the partial product and enters RUN. mul_busy rises the next cycle.
  - RUN: exactly AW cycles, one multiplier bit per cycle, LSB first.
  - On the edge leaving RUN: AC <= product[DW-1:0], MQ <= product[DW+AW-1:DW] zero-extended. Enter DONE.
  - DONE: mul_done=1 and mul_busy=0 for one cycle, then IDLE.
  - Total latency: mul_start edge to result visible in AC is AW+1 edges.
- While mul_busy=1 or mul_done=1: all AC strobes and mul_start are ignored. PC, IR, carry and adr operate normally.
- The multiplier never changes carry.

Test Plan:
1. Assert rst asynchronously mid-multiply, with AC=0x1234 and bus_err=1 -> all registers and flags read 0 before the next clock edge; mul_busy=0.
2. Load AC=0xFFFF from mem_rdata; IR=0x0001; alu_op=ADD, dbus_sel=1, ld_ac -> AC=0x0000, carry_flag=1, zero_flag=1. Then ADDC with the same IR -> AC=0x0002, carry_flag=0.
3. AC=0x1234, IR operand=0x0010, pulse mul_start:
   - mul_busy high for 13 cycles, then AC=0x2340, mq=0x0001, mul_done high exactly one cycle.
   - ld_ac asserted during busy has no effect.
4. PC=0x1FFF, inc_pc -> PC=0x0000. Load IR=0x6ABC, ld_pc -> PC=0x0ABC, op_code=3. clr_pc and inc_pc together -> PC=0.
5. pc_on_adr=1 and ir_on_adr=1 for one cycle -> adr=PC, bus_err=1 and held after both deassert. Both deasserted -> adr=0. bus_err clears only on rst.
6. ac_zero and ld_ac together with dbus=0x00FF -> AC=0. SUB with AC=0x0003, operand 0x0005 -> AC=0xFFFE, carry_flag=0.
